clk_div_sched: RTL and testbench
================================

Name: clk_div_sched

Overview:
- Run-time controller for the divided-clock path: owns a programmable divide counter, accepts new divide ratios over a valid/ready handshake and applies them only at period boundaries, so the output never glitches.
- Also sequences clean start/stop: the output always starts high and always stops low.
- Sits between the register/config interface and any logic clocked or enabled by the divided clock.

Parameters:
- CNT_W, 16, width of divide ratio and internal counter
- DEF_DIV, 4, ratio loaded at reset; must be >= 2 and < 2**CNT_W

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  run request; level-sensitive
- cfg_valid  in  1  new ratio offered
- cfg_div  in  CNT_W  requested divide ratio N
- cfg_ready  out  1  controller can accept a ratio this cycle
- cfg_err  out  1  one-cycle pulse: accepted ratio was illegal (N < 2) and was discarded
- div_out  out  1  divided clock level, registered
- tick  out  1  one-cycle pulse on every 0->1 transition of div_out
- busy  out  1  high in RUN, PEND and STOP

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0 except cfg_ready = 1. Active ratio = DEF_DIV, cnt = 0, state = IDLE.
- Period shape for active ratio N:
  - H = floor(N/2) cycles high, then N-H cycles low.
  - Internal cnt runs 0..N-1; div_out is high while cnt < H.
  - Odd N gives the longer low phase. Example: N=5 gives 2 high, 3 low.
- Boundary: the cycle in which cnt == N-1. On the next edge cnt becomes 0, and any pending ratio loads on that same edge.
- IDLE state:
  - div_out = 0, cnt held at 0.
  - On en = 1, go to RUN. The next edge sets div_out = 1 and tick = 1, which is cycle 0 of the first period.
- RUN state:
  - Counter free-runs.
  - On a cfg handshake, latch the new ratio into the pending register and go to PEND.
  - If en drops, go to STOP.
- PEND state:
  - cfg_ready = 0.
  - At the boundary, load the pending ratio, clear pending, return to RUN. The first period of the new ratio starts with tick.
  - If en drops, go to STOP and keep the pending ratio.
- STOP state:
  - Finish the current period up to and including the boundary cycle.
  - After the boundary, go to IDLE with div_out = 0.
  - Any pending ratio loads at that boundary.
  - If en reasserts before the boundary, return to RUN (or PEND if a ratio is pending) with no phase disturbance.
- Handshake:
  - Transfer occurs when cfg_valid && cfg_ready.
  - cfg_ready = 1 in IDLE, RUN and STOP with nothing pending; 0 while a ratio is pending.
  - In IDLE, an accepted ratio loads into the active register on the same edge; no pending state is used.
  - Illegal N (0 or 1): the handshake still completes, cfg_err pulses on the next cycle, and both active and pending ratios are unchanged.
- Simultaneous events:
  - A handshake in the boundary cycle of RUN is treated as pending and applies at the next boundary, not the current one.
  - en falling and a handshake in the same RUN cycle: the ratio is latched as pending and the state goes to STOP.
- tick: asserted exactly in the cycles where div_out is 1 and was 0 in the previous cycle. Never asserted outside RUN/PEND/STOP.
- Reset mid-operation: outputs return to reset values immediately (asynchronous). Pending ratio is discarded; active ratio returns to DEF_DIV.
- Width: cnt compare and ratio are CNT_W bits unsigned. N = 2**CNT_W-1 is legal and must not wrap.

Optional Feature:
- Macro: CLK_DIV_SCHED_STATUS_EN.
- Defined: adds two outputs.
  - cur_div out CNT_W: the active ratio.
  - pend out 1: a ratio is pending.
  - Both are registered and update on the same edge as the internal registers.
- Undefined: these ports are absent; core behaviour is identical.

Test Plan:
- Reset with DEF_DIV=4, then en=1 -> div_out pattern 1,1,0,0 repeating; tick on each first-high cycle; busy=1.
- Running at N=4, cfg_div=6 accepted at cnt=1 -> cfg_ready=0 until the boundary, current period finishes as 1,1,0,0, then 1,1,1,0,0,0; tick at the switch.
- cfg_div=1 offered while running -> handshake completes, cfg_err=1 for one cycle, ratio stays 4, waveform unchanged.
- Running at N=5, en=0 at cnt=1 -> period completes as 1,1,0,0,0, then div_out=0 and busy=0 in IDLE; en=1 later restarts with div_out=1 and tick.
- In IDLE, load cfg_div=3 then en=1 -> pattern 1,0,0 repeating; handshake in the boundary cycle applies one period later.
- Drive rst_n low mid-high-phase with a ratio pending -> div_out=0 immediately, cfg_ready=1; after release and en=1, runs at DEF_DIV.

Source files
------------

// File: rtl/clk_div_sched.sv
// clk_div_sched: run-time controller for a glitch-free programmable clock divider.
//
// A divide ratio N gives floor(N/2) cycles high followed by N-floor(N/2) cycles low.
// New ratios arrive over cfg_valid/cfg_ready and are only applied at a period
// boundary. Start-up always begins with a high phase and shut-down always finishes
// the current period, so div_out never produces a runt pulse.
//
// Handshake: a transfer happens on every rising clk edge where cfg_valid && cfg_ready.
// The offer (cfg_div) must be held stable while cfg_valid is high and cfg_ready is low.
//
// Optional build macro CLK_DIV_SCHED_STATUS_EN adds the status outputs cur_div
// (active ratio) and pend (a ratio is waiting for the next boundary).
module clk_div_sched #(
    parameter int CNT_W   = 16,
    parameter int DEF_DIV = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             div_out,
    output logic             tick,
    output logic             busy
`ifdef CLK_DIV_SCHED_STATUS_EN
    ,
    output logic [CNT_W-1:0] cur_div,
    output logic             pend
`endif
);

    localparam logic [CNT_W-1:0] DEF_RATIO = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO       = CNT_W'(2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_PEND = 2'd2,
        S_STOP = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] ratio_q, ratio_d;
    logic [CNT_W-1:0] pdiv_q, pdiv_d;
    logic             pvalid_q, pvalid_d;
    logic             live_q, live_d;     // cnt_q names a real period cycle
    logic             div_q, div_d;
    logic             tick_q, tick_d;
    logic             err_q, err_d;

    logic             xfer;
    logic             take;
    logic             boundary;
    logic             stop_end;
    logic             load_pend;

    // Shared event decode used by both the FSM and the datapath
    always_comb begin
        xfer      = cfg_valid && cfg_ready;
        take      = xfer && (cfg_div >= TWO);
        boundary  = live_q && (cnt_q == (ratio_q - ONE));
        stop_end  = (state_q == S_STOP) && !en && (boundary || !live_q);
        load_pend = boundary && pvalid_q;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (en) state_d = S_RUN;
            end
            S_RUN: begin
                if (!en)       state_d = S_STOP;
                else if (take) state_d = S_PEND;
            end
            S_PEND: begin
                if (!en)           state_d = S_STOP;
                else if (boundary) state_d = S_RUN;
            end
            S_STOP: begin
                if (en) begin
                    // A pending ratio consumed at this boundary leaves nothing pending
                    if (boundary) state_d = take ? S_PEND : S_RUN;
                    else          state_d = (pvalid_q || take) ? S_PEND : S_RUN;
                end else if (boundary || !live_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs decoded from registered state
    always_comb begin
        busy      = (state_q != S_IDLE);
        cfg_ready = !pvalid_q;
    end

    // Ratio registers, period counter and waveform generation
    always_comb begin
        ratio_d  = ratio_q;
        pdiv_d   = pdiv_q;
        pvalid_d = pvalid_q;
        cnt_d    = cnt_q;
        live_d   = live_q;
        div_d    = div_q;
        err_d    = xfer && !take;

        // take implies nothing pending, so these loads never collide
        if (state_q == S_IDLE) begin
            if (take) ratio_d = cfg_div;
        end else if (load_pend) begin
            ratio_d  = pdiv_q;
            pvalid_d = 1'b0;
        end else if (take) begin
            if (stop_end) begin
                // Shutting down now: no later boundary exists to apply it at
                ratio_d = cfg_div;
            end else begin
                pdiv_d   = cfg_div;
                pvalid_d = 1'b1;
            end
        end

        if ((state_q == S_IDLE) || stop_end) begin
            cnt_d  = '0;
            live_d = 1'b0;
            div_d  = 1'b0;
        end else if (!live_q) begin
            // First cycle of the first period always starts high
            cnt_d  = '0;
            live_d = 1'b1;
            div_d  = 1'b1;
        end else begin
            cnt_d = boundary ? '0 : (cnt_q + ONE);
            div_d = (cnt_d < (ratio_d >> 1));
        end

        tick_d = div_d && !div_q;
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ratio_q  <= DEF_RATIO;
            pdiv_q   <= '0;
            pvalid_q <= 1'b0;
            cnt_q    <= '0;
            live_q   <= 1'b0;
            div_q    <= 1'b0;
            tick_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            ratio_q  <= ratio_d;
            pdiv_q   <= pdiv_d;
            pvalid_q <= pvalid_d;
            cnt_q    <= cnt_d;
            live_q   <= live_d;
            div_q    <= div_d;
            tick_q   <= tick_d;
            err_q    <= err_d;
        end
    end

    assign div_out = div_q;
    assign tick    = tick_q;
    assign cfg_err = err_q;

`ifdef CLK_DIV_SCHED_STATUS_EN
    assign cur_div = ratio_q;
    assign pend    = pvalid_q;
`endif

endmodule

// File: tb/tb_clk_div_sched.sv
// tb_clk_div_sched: table-driven directed bench for clk_div_sched (DEF_DIV = 4).
// Each row gives the inputs for one clock cycle and the outputs expected just
// after the following rising edge.
module tb_clk_div_sched;

    localparam int CNT_W = 16;

    typedef struct {
        logic             en;
        logic             vld;
        logic [CNT_W-1:0] div;
        logic             e_div;
        logic             e_tick;
        logic             e_busy;
        logic             e_rdy;
        logic             e_err;
    } vec_t;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_err;
    logic             div_out;
    logic             tick;
    logic             busy;
`ifdef CLK_DIV_SCHED_STATUS_EN
    logic [CNT_W-1:0] cur_div;
    logic             pend;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    vec_t tbl_a[$];
    vec_t tbl_b[$];

    clk_div_sched #(.CNT_W(CNT_W), .DEF_DIV(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .div_out   (div_out),
        .tick      (tick),
        .busy      (busy)
`ifdef CLK_DIV_SCHED_STATUS_EN
        ,
        .cur_div   (cur_div),
        .pend      (pend)
`endif
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %b expected %b", name, idx, act, exp);
        end
    endtask

    task automatic add(ref vec_t q[$], input logic i_en, input logic i_vld, input int i_div,
                       input logic d, input logic t, input logic b, input logic r, input logic e);
        vec_t v;
        v.en = i_en; v.vld = i_vld; v.div = CNT_W'(i_div);
        v.e_div = d; v.e_tick = t; v.e_busy = b; v.e_rdy = r; v.e_err = e;
        q.push_back(v);
    endtask

    task automatic apply_row(input vec_t v, input int idx);
        en        = v.en;
        cfg_valid = v.vld;
        cfg_div   = v.div;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        cfg_div   = '0;
        check("div_out",   idx, div_out,   v.e_div);
        check("tick",      idx, tick,      v.e_tick);
        check("busy",      idx, busy,      v.e_busy);
        check("cfg_ready", idx, cfg_ready, v.e_rdy);
        check("cfg_err",   idx, cfg_err,   v.e_err);
`ifdef CLK_DIV_SCHED_STATUS_EN
        check("pend",      idx, pend,      !v.e_rdy);
`endif
    endtask

    initial begin
        //               en vld div   div tick busy rdy err
        // start-up at DEF_DIV=4
        add(tbl_a, 1, 0, 0,   0, 0, 1, 1, 0);
        add(tbl_a, 1, 0, 0,   1, 1, 1, 1, 0);
        add(tbl_a, 1, 0, 0,   1, 0, 1, 1, 0);
        add(tbl_a, 1, 0, 0,   0, 0, 1, 1, 0);
        add(tbl_a, 1, 0, 0,   0, 0, 1, 1, 0);
        add(tbl_a, 1, 0, 0,   1, 1, 1, 1, 0);
        add(tbl_a, 1, 0, 0,   1, 0, 1, 1, 0);
        // N=6 offered in the cnt=1 cycle, applies at the boundary
        add(tbl_a, 1, 1, 6,   0, 0, 1, 0, 0);
        add(tbl_a, 1, 0, 0,   0, 0, 1, 0, 0);
        add(tbl_a, 1, 0, 0,   1, 1, 1, 1, 0);
        add(tbl_a, 1, 0, 0,   1, 0, 1, 1, 0);
        add(tbl_a, 1, 0, 0,   1, 0, 1, 1, 0);
        add(tbl_a, 1, 0, 0,   0, 0, 1, 1, 0);
        add(tbl_a, 1, 0, 0,   0, 0, 1, 1, 0);
        add(tbl_a, 1, 0, 0,   0, 0, 1, 1, 0);
        add(tbl_a, 1, 0, 0,   1, 1, 1, 1, 0);
        // illegal N=1 while running: error pulse, waveform unchanged
        add(tbl_a, 1, 1, 1,   1, 0, 1, 1, 1);
        add(tbl_a, 1, 0, 0,   1, 0, 1, 1, 0);
        add(tbl_a, 1, 0, 0,   0, 0, 1, 1, 0);
        add(tbl_a, 1, 0, 0,   0, 0, 1, 1, 0);
        add(tbl_a, 1, 0, 0,   0, 0, 1, 1, 0);
        add(tbl_a, 1, 0, 0,   1, 1, 1, 1, 0);
        // switch to N=5
        add(tbl_a, 1, 1, 5,   1, 0, 1, 0, 0);
        add(tbl_a, 1, 0, 0,   1, 0, 1, 0, 0);
        add(tbl_a, 1, 0, 0,   0, 0, 1, 0, 0);
        add(tbl_a, 1, 0, 0,   0, 0, 1, 0, 0);
        add(tbl_a, 1, 0, 0,   0, 0, 1, 0, 0);
        add(tbl_a, 1, 0, 0,   1, 1, 1, 1, 0);
        add(tbl_a, 1, 0, 0,   1, 0, 1, 1, 0);
        // en drops at cnt=1: period completes as 1,1,0,0,0 then IDLE
        add(tbl_a, 0, 0, 0,   0, 0, 1, 1, 0);
        add(tbl_a, 0, 0, 0,   0, 0, 1, 1, 0);
        add(tbl_a, 0, 0, 0,   0, 0, 1, 1, 0);
        add(tbl_a, 0, 0, 0,   0, 0, 0, 1, 0);
        add(tbl_a, 0, 0, 0,   0, 0, 0, 1, 0);
        // IDLE: load N=3 directly, then illegal N=0
        add(tbl_a, 0, 1, 3,   0, 0, 0, 1, 0);
        add(tbl_a, 0, 1, 0,   0, 0, 0, 1, 1);
        add(tbl_a, 1, 0, 0,   0, 0, 1, 1, 0);
        add(tbl_a, 1, 0, 0,   1, 1, 1, 1, 0);
        add(tbl_a, 1, 0, 0,   0, 0, 1, 1, 0);
        add(tbl_a, 1, 0, 0,   0, 0, 1, 1, 0);
        // handshake in the N=3 boundary cycle: one more N=3 period, then N=4
        add(tbl_a, 1, 1, 4,   1, 1, 1, 0, 0);
        add(tbl_a, 1, 0, 0,   0, 0, 1, 0, 0);
        add(tbl_a, 1, 0, 0,   0, 0, 1, 0, 0);
        add(tbl_a, 1, 0, 0,   1, 1, 1, 1, 0);
        add(tbl_a, 1, 0, 0,   1, 0, 1, 1, 0);
        add(tbl_a, 1, 0, 0,   0, 0, 1, 1, 0);
        // N=7 at cnt=2 loads at the boundary, then N=9 left pending mid-high
        add(tbl_a, 1, 1, 7,   0, 0, 1, 0, 0);
        add(tbl_a, 1, 0, 0,   1, 1, 1, 1, 0);
        add(tbl_a, 1, 1, 9,   1, 0, 1, 0, 0);

        // after reset: back to N=4
        add(tbl_b, 1, 0, 0,   0, 0, 1, 1, 0);
        add(tbl_b, 1, 0, 0,   1, 1, 1, 1, 0);
        add(tbl_b, 1, 0, 0,   1, 0, 1, 1, 0);
        add(tbl_b, 1, 0, 0,   0, 0, 1, 1, 0);
        add(tbl_b, 1, 0, 0,   0, 0, 1, 1, 0);
        add(tbl_b, 1, 0, 0,   1, 1, 1, 1, 0);
        add(tbl_b, 1, 0, 0,   1, 0, 1, 1, 0);
        // brief en drop and reassert before the boundary: no phase change
        add(tbl_b, 0, 0, 0,   0, 0, 1, 1, 0);
        add(tbl_b, 1, 0, 0,   0, 0, 1, 1, 0);
        add(tbl_b, 1, 0, 0,   1, 1, 1, 1, 0);
        add(tbl_b, 1, 0, 0,   1, 0, 1, 1, 0);
        add(tbl_b, 0, 0, 0,   0, 0, 1, 1, 0);
        add(tbl_b, 0, 0, 0,   0, 0, 1, 1, 0);
        add(tbl_b, 0, 0, 0,   0, 0, 0, 1, 0);
        // en drop together with a handshake: pending N=2 loads at the stop boundary
        add(tbl_b, 1, 0, 0,   0, 0, 1, 1, 0);
        add(tbl_b, 1, 0, 0,   1, 1, 1, 1, 0);
        add(tbl_b, 0, 1, 2,   1, 0, 1, 0, 0);
        add(tbl_b, 0, 0, 0,   0, 0, 1, 0, 0);
        add(tbl_b, 0, 0, 0,   0, 0, 1, 0, 0);
        add(tbl_b, 0, 0, 0,   0, 0, 0, 1, 0);
        add(tbl_b, 1, 0, 0,   0, 0, 1, 1, 0);
        add(tbl_b, 1, 0, 0,   1, 1, 1, 1, 0);
        add(tbl_b, 1, 0, 0,   0, 0, 1, 1, 0);
        add(tbl_b, 1, 0, 0,   1, 1, 1, 1, 0);

        // Reset
        rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_div_out",   -1, div_out,   1'b0);
        check("rst_tick",      -1, tick,      1'b0);
        check("rst_busy",      -1, busy,      1'b0);
        check("rst_cfg_ready", -1, cfg_ready, 1'b1);
        check("rst_cfg_err",   -1, cfg_err,   1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl_a[i]) apply_row(tbl_a[i], i);

        // Asynchronous reset mid-high-phase with a ratio pending
        #2;
        rst_n = 1'b0;
        #1;
        check("amid_div_out",   100, div_out,   1'b0);
        check("amid_tick",      100, tick,      1'b0);
        check("amid_busy",      100, busy,      1'b0);
        check("amid_cfg_ready", 100, cfg_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl_b[i]) apply_row(tbl_b[i], 200 + i);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
